// File: rtl/mem_refill_port_arbiter.sv
// Shares one refill/evict memory port between two blocking caches, with one
// transaction in flight and round-robin grant. Responses are routed back to the granted requester only.
module mem_refill_port_arbiter #(
  parameter  int p_opaque_nbits = 8,
  parameter  int abw            = 32,
  parameter  int clw            = 128,
  localparam int lenw           = $clog2(clw/8),
  localparam int reqw           = 3 + p_opaque_nbits + abw + lenw + clw,
  localparam int respw          = 3 + p_opaque_nbits + lenw + clw
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [reqw-1:0]  req0_msg,
  input  logic             req0_val,
  output logic             req0_rdy,
  input  logic             req0_domain,
  input  logic [reqw-1:0]  req1_msg,
  input  logic             req1_val,
  output logic             req1_rdy,
  input  logic             req1_domain,
  output logic [respw-1:0] resp0_msg,
  output logic             resp0_val,
  input  logic             resp0_rdy,
  output logic             resp0_domain,
  output logic             fail0,
  output logic [respw-1:0] resp1_msg,
  output logic             resp1_val,
  input  logic             resp1_rdy,
  output logic             resp1_domain,
  output logic             fail1,
  output logic [reqw-1:0]  memreq_msg,
  output logic             memreq_val,
  input  logic             memreq_rdy,
  output logic             memreq_domain,
  input  logic [respw-1:0] memresp_msg,
  input  logic             memresp_val,
  output logic             memresp_rdy,
  input  logic             memresp_domain,
  input  logic             fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic             gnt_r, gnt_s;
  logic             prio_r, prio_s;
  logic             dom_r, dom_s;
  logic             g_req_val_s;
  logic             g_resp_rdy_s;
  logic             guard_s;
  logic [clw-1:0]   resp_data_s;
  logic [respw-1:0] resp_msg_s;

  // Granted-side selects and the domain-escalation guard.
  always_comb begin
    g_req_val_s  = gnt_r ? req1_val  : req0_val;
    g_resp_rdy_s = gnt_r ? resp1_rdy : resp0_rdy;
    guard_s      = memresp_val & memresp_domain & ~dom_r;
    resp_data_s  = guard_s ? {clw{1'b0}} : memresp_msg[clw-1:0];
    resp_msg_s   = {memresp_msg[respw-1:clw], resp_data_s};
  end

  // State, grant, priority and latched-domain registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      gnt_r   <= 1'b0;
      prio_r  <= 1'b0;
      dom_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      prio_r  <= prio_s;
      dom_r   <= dom_s;
    end
  end

  // Next-state and arbitration logic.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    prio_s  = prio_r;
    dom_s   = dom_r;
    case (state_r)
      IDLE: begin
        if (req0_val && req1_val) begin
          gnt_s   = prio_r;
          dom_s   = prio_r ? req1_domain : req0_domain;
          state_s = SEND;
        end else if (req0_val) begin
          gnt_s   = 1'b0;
          dom_s   = req0_domain;
          state_s = SEND;
        end else if (req1_val) begin
          gnt_s   = 1'b1;
          dom_s   = req1_domain;
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        // A requester withdrawing val before acceptance forfeits its turn without rotating priority.
        if (!g_req_val_s) begin
          state_s = IDLE;
        end else if (memreq_rdy) begin
          state_s = WAIT;
          prio_s  = ~gnt_r;
        end else begin
          state_s = SEND;
        end
      end
      WAIT: begin
        if (memresp_val && g_resp_rdy_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output routing; everything is zero outside the active phase.
  always_comb begin
    req0_rdy      = 1'b0;
    req1_rdy      = 1'b0;
    resp0_msg     = {respw{1'b0}};
    resp0_val     = 1'b0;
    resp0_domain  = 1'b0;
    fail0         = 1'b0;
    resp1_msg     = {respw{1'b0}};
    resp1_val     = 1'b0;
    resp1_domain  = 1'b0;
    fail1         = 1'b0;
    memreq_msg    = {reqw{1'b0}};
    memreq_val    = 1'b0;
    memreq_domain = 1'b0;
    memresp_rdy   = 1'b0;
    case (state_r)
      SEND: begin
        memreq_msg    = gnt_r ? req1_msg : req0_msg;
        memreq_domain = gnt_r ? req1_domain : req0_domain;
        memreq_val    = g_req_val_s;
        if (gnt_r) begin
          req1_rdy = memreq_rdy;
        end else begin
          req0_rdy = memreq_rdy;
        end
      end
      WAIT: begin
        memresp_rdy = g_resp_rdy_s;
        if (gnt_r) begin
          resp1_val    = memresp_val;
          resp1_msg    = resp_msg_s;
          resp1_domain = memresp_domain;
          fail1        = (fail & memresp_val) | guard_s;
        end else begin
          resp0_val    = memresp_val;
          resp0_msg    = resp_msg_s;
          resp0_domain = memresp_domain;
          fail0        = (fail & memresp_val) | guard_s;
        end
      end
      default: begin
        memresp_rdy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_refill_port_arbiter.sv
// Directed bench for mem_refill_port_arbiter: the bench plays both caches and
// the memory; expectations are queued at issue time and checked by a monitor.
module tb_mem_refill_port_arbiter;

  localparam int REQW  = 175;
  localparam int RESPW = 143;

  logic             clk = 1'b0;
  logic             reset;
  logic [REQW-1:0]  req0_msg, req1_msg, memreq_msg;
  logic             req0_val, req1_val, req0_rdy, req1_rdy, req0_domain, req1_domain;
  logic [RESPW-1:0] resp0_msg, resp1_msg, memresp_msg;
  logic             resp0_val, resp1_val, resp0_rdy, resp1_rdy;
  logic             resp0_domain, resp1_domain, fail0, fail1;
  logic             memreq_val, memreq_rdy, memreq_domain;
  logic             memresp_val, memresp_rdy, memresp_domain, fail;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [REQW-1:0] msg;
    logic            dom;
  } req_exp_t;

  typedef struct packed {
    logic             port;
    logic [RESPW-1:0] msg;
    logic             fail;
    logic             dom;
  } resp_exp_t;

  req_exp_t  exp_req_q[$];
  resp_exp_t exp_resp_q[$];

  logic [471:0] all_outs;
  assign all_outs = {req0_rdy, req1_rdy, resp0_msg, resp1_msg, resp0_val, resp1_val,
                     resp0_domain, resp1_domain, fail0, fail1, memreq_msg, memreq_val,
                     memreq_domain, memresp_rdy};

  mem_refill_port_arbiter #(.p_opaque_nbits(8), .abw(32), .clw(128)) dut (
    .clk(clk), .reset(reset),
    .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_domain(req0_domain),
    .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_domain(req1_domain),
    .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .resp0_domain(resp0_domain), .fail0(fail0),
    .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .resp1_domain(resp1_domain), .fail1(fail1),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memreq_domain(memreq_domain),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .memresp_domain(memresp_domain), .fail(fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [REQW-1:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                             input logic [31:0] a, input logic [127:0] d);
    return {t, op, a, 4'd0, d};
  endfunction

  function automatic logic [RESPW-1:0] mk_resp(input logic [2:0] t, input logic [7:0] op,
                                               input logic [127:0] d);
    return {t, op, 4'd0, d};
  endfunction

  task automatic check_resp(input logic port, input logic [RESPW-1:0] msg,
                            input logic f, input logic d);
    resp_exp_t e;
    if (exp_resp_q.size() == 0) begin
      chk("resp_unexpected", 512'd1, 512'd0);
    end else begin
      e = exp_resp_q.pop_front();
      chk("resp_port", {511'd0, port}, {511'd0, e.port});
      chk("resp_msg", {369'd0, msg}, {369'd0, e.msg});
      chk("resp_fail", {511'd0, f}, {511'd0, e.fail});
      chk("resp_domain", {511'd0, d}, {511'd0, e.dom});
    end
  endtask

  // Scoreboard monitor: samples handshakes just before each rising edge.
  always begin
    req_exp_t r;
    @(negedge clk);
    #3;
    if (memreq_val && memreq_rdy) begin
      if (exp_req_q.size() == 0) begin
        chk("memreq_unexpected", 512'd1, 512'd0);
      end else begin
        r = exp_req_q.pop_front();
        chk("memreq_msg", {337'd0, memreq_msg}, {337'd0, r.msg});
        chk("memreq_domain", {511'd0, memreq_domain}, {511'd0, r.dom});
      end
    end
    if (resp0_val && resp0_rdy) check_resp(1'b0, resp0_msg, fail0, resp0_domain);
    if (resp1_val && resp1_rdy) check_resp(1'b1, resp1_msg, fail1, resp1_domain);
  end

  // One full transaction on requester `port`, starting from IDLE at a falling edge.
  task automatic run_txn(input logic port, input logic [REQW-1:0] rq, input logic rdom,
                         input int rq_stall, input logic [RESPW-1:0] rs, input logic rsdom,
                         input logic rsfail, input int rs_stall,
                         input logic [RESPW-1:0] exp_rs, input logic exp_fail);
    exp_req_q.push_back('{msg: rq, dom: rdom});
    exp_resp_q.push_back('{port: port, msg: exp_rs, fail: exp_fail, dom: rsdom});
    if (port) begin
      req1_val = 1'b1; req1_msg = rq; req1_domain = rdom;
    end else begin
      req0_val = 1'b1; req0_msg = rq; req0_domain = rdom;
    end
    memreq_rdy = (rq_stall == 0);
    #1;
    chk("idle_memreq_val", {511'd0, memreq_val}, 512'd0);
    chk("idle_req_rdy", {510'd0, req0_rdy, req1_rdy}, 512'd0);
    @(negedge clk);
    for (int i = 0; i < rq_stall; i++) begin
      #1;
      chk("stall_memreq_val", {511'd0, memreq_val}, 512'd1);
      chk("stall_req_rdy", {511'd0, (port ? req1_rdy : req0_rdy)}, 512'd0);
      @(negedge clk);
    end
    memreq_rdy = 1'b1;
    #1;
    chk("send_memreq_val", {511'd0, memreq_val}, 512'd1);
    chk("send_gnt_rdy", {511'd0, (port ? req1_rdy : req0_rdy)}, 512'd1);
    chk("send_other_rdy", {511'd0, (port ? req0_rdy : req1_rdy)}, 512'd0);
    @(negedge clk);
    if (port) req1_val = 1'b0;
    else      req0_val = 1'b0;
    memresp_val = 1'b1; memresp_msg = rs; memresp_domain = rsdom; fail = rsfail;
    if (port) resp1_rdy = (rs_stall == 0);
    else      resp0_rdy = (rs_stall == 0);
    for (int i = 0; i < rs_stall; i++) begin
      #1;
      chk("rstall_memresp_rdy", {511'd0, memresp_rdy}, 512'd0);
      chk("rstall_resp_val", {511'd0, (port ? resp1_val : resp0_val)}, 512'd1);
      @(negedge clk);
    end
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    #1;
    chk("wait_memresp_rdy", {511'd0, memresp_rdy}, 512'd1);
    chk("wait_other_resp_val", {511'd0, (port ? resp0_val : resp1_val)}, 512'd0);
    @(negedge clk);
    memresp_val = 1'b0; memresp_domain = 1'b0; fail = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_outputs", {40'd0, all_outs}, 512'd0);
    reset = 1'b1;
  endtask

  localparam logic [127:0] BIG = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

  initial begin
    reset = 1'b0;
    req0_msg = '0; req1_msg = '0; req0_val = 1'b0; req1_val = 1'b0;
    req0_domain = 1'b0; req1_domain = 1'b0;
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    memreq_rdy = 1'b0; memresp_msg = '0; memresp_val = 1'b0;
    memresp_domain = 1'b0; fail = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Single request, minimum round trip
    run_txn(1'b0, mk_req(3'd0, 8'h11, 32'h100, 128'd0), 1'b0, 0,
            mk_resp(3'd0, 8'h11, 128'h1234), 1'b0, 1'b0, 0,
            mk_resp(3'd0, 8'h11, 128'h1234), 1'b0);

    // Simultaneous requests after reset: 0, 1, then 0, 1 again
    do_reset();
    req1_val = 1'b1; req1_msg = mk_req(3'd0, 8'h21, 32'h200, 128'd0);
    run_txn(1'b0, mk_req(3'd0, 8'h20, 32'h180, 128'd0), 1'b0, 0,
            mk_resp(3'd0, 8'h20, 128'hA0), 1'b0, 1'b0, 0, mk_resp(3'd0, 8'h20, 128'hA0), 1'b0);
    run_txn(1'b1, mk_req(3'd0, 8'h21, 32'h200, 128'd0), 1'b0, 0,
            mk_resp(3'd0, 8'h21, 128'hA1), 1'b0, 1'b0, 0, mk_resp(3'd0, 8'h21, 128'hA1), 1'b0);
    req1_val = 1'b1; req1_msg = mk_req(3'd1, 8'h31, 32'h300, 128'h55);
    run_txn(1'b0, mk_req(3'd1, 8'h30, 32'h280, 128'h44), 1'b1, 0,
            mk_resp(3'd1, 8'h30, 128'd0), 1'b0, 1'b0, 0, mk_resp(3'd1, 8'h30, 128'd0), 1'b0);
    run_txn(1'b1, mk_req(3'd1, 8'h31, 32'h300, 128'h55), 1'b0, 0,
            mk_resp(3'd1, 8'h31, 128'd0), 1'b0, 1'b0, 0, mk_resp(3'd1, 8'h31, 128'd0), 1'b0);

    // Request backpressure: 3 stalled cycles, then priority moves to 1
    req1_val = 1'b1; req1_msg = mk_req(3'd0, 8'h41, 32'h400, 128'd0);
    run_txn(1'b0, mk_req(3'd0, 8'h40, 32'h380, 128'd0), 1'b0, 3,
            mk_resp(3'd0, 8'h40, 128'hB0), 1'b0, 1'b0, 0, mk_resp(3'd0, 8'h40, 128'hB0), 1'b0);
    req0_val = 1'b1; req0_msg = mk_req(3'd0, 8'h42, 32'h480, 128'd0);
    run_txn(1'b1, mk_req(3'd0, 8'h41, 32'h400, 128'd0), 1'b0, 0,
            mk_resp(3'd0, 8'h41, 128'hB1), 1'b0, 1'b1, 0, mk_resp(3'd0, 8'h41, 128'hB1), 1'b1);
    run_txn(1'b0, mk_req(3'd0, 8'h42, 32'h480, 128'd0), 1'b0, 0,
            mk_resp(3'd0, 8'h42, 128'hB2), 1'b0, 1'b0, 0, mk_resp(3'd0, 8'h42, 128'hB2), 1'b0);

    // Response backpressure on requester 1
    run_txn(1'b1, mk_req(3'd0, 8'h50, 32'h500, 128'd0), 1'b1, 0,
            mk_resp(3'd0, 8'h50, 128'hC0FFEE), 1'b1, 1'b0, 2,
            mk_resp(3'd0, 8'h50, 128'hC0FFEE), 1'b0);

    // Domain guard: non-secure request receiving secure data is blanked
    run_txn(1'b0, mk_req(3'd0, 8'h5A, 32'h600, 128'd0), 1'b0, 0,
            mk_resp(3'd0, 8'h5A, BIG), 1'b1, 1'b0, 0, mk_resp(3'd0, 8'h5A, 128'd0), 1'b1);
    run_txn(1'b0, mk_req(3'd0, 8'h5B, 32'h640, 128'd0), 1'b1, 0,
            mk_resp(3'd0, 8'h5B, BIG), 1'b1, 1'b0, 0, mk_resp(3'd0, 8'h5B, BIG), 1'b0);
    run_txn(1'b0, mk_req(3'd0, 8'h5C, 32'h680, 128'd0), 1'b1, 0,
            mk_resp(3'd0, 8'h5C, BIG), 1'b1, 1'b1, 0, mk_resp(3'd0, 8'h5C, BIG), 1'b1);
    run_txn(1'b1, mk_req(3'd1, 8'h77, 32'h6C0, BIG), 1'b0, 0,
            mk_resp(3'd1, 8'h77, BIG), 1'b1, 1'b0, 0, mk_resp(3'd1, 8'h77, 128'd0), 1'b1);

    // Reset while waiting for a response, then a spurious response and a fresh request
    req0_val = 1'b1; req0_msg = mk_req(3'd0, 8'h60, 32'h700, 128'd0); req0_domain = 1'b0;
    memreq_rdy = 1'b1;
    exp_req_q.push_back('{msg: mk_req(3'd0, 8'h60, 32'h700, 128'd0), dom: 1'b0});
    @(negedge clk);
    #1;
    chk("rst_send_memreq_val", {511'd0, memreq_val}, 512'd1);
    @(negedge clk);
    req0_val = 1'b0;
    do_reset();
    memresp_val = 1'b1; memresp_msg = mk_resp(3'd0, 8'h60, 128'h99); memresp_domain = 1'b0;
    #1;
    chk("spurious_resp_val", {510'd0, resp0_val, resp1_val}, 512'd0);
    chk("spurious_memresp_rdy", {511'd0, memresp_rdy}, 512'd0);
    @(negedge clk);
    memresp_val = 1'b0;
    run_txn(1'b1, mk_req(3'd0, 8'h61, 32'h740, 128'd0), 1'b0, 0,
            mk_resp(3'd0, 8'h61, 128'h77), 1'b0, 1'b0, 0, mk_resp(3'd0, 8'h61, 128'h77), 1'b0);

    repeat (2) @(negedge clk);
    chk("memreq_queue_empty", {480'd0, 32'(exp_req_q.size())}, 512'd0);
    chk("resp_queue_empty", {480'd0, 32'(exp_resp_q.size())}, 512'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_refill_port_arbiter.md
# mem_refill_port_arbiter

Two-requester arbiter that shares one refill/evict memory port between two blocking L1 caches, e.g. I-cache and D-cache. It sits between the caches' `memreq`/`memresp` ports and the single downstream memory port. It allows one transaction in flight at a time and uses round-robin grant between requesters. It routes the response, `fail`, and security domain back only to the granted requester, and it blanks data on a domain-escalating response.

## Interface
- `p_opaque_nbits`, 8, opaque field width (`o`)
- `abw`, 32, address width
- `clw`, 128, cache-line data width
- `clk` in 1: clock
- `reset` in 1: synchronous, active-low reset (asserted when 0, sampled on rising `clk`)
- `req0_msg`, `req1_msg` in `VC_MEM_REQ_MSG_NBITS(o,abw,clw)`: requester memory requests
- `req0_val`, `req1_val` in 1; `req0_rdy`, `req1_rdy` out 1: request handshakes
- `req0_domain`, `req1_domain` in 1: request security domain (1 = secure)
- `resp0_msg`, `resp1_msg` out `VC_MEM_RESP_MSG_NBITS(o,clw)`: routed responses
- `resp0_val`, `resp1_val` out 1; `resp0_rdy`, `resp1_rdy` in 1: response handshakes
- `resp0_domain`, `resp1_domain` out 1; `fail0`, `fail1` out 1: routed domain / access-denied
- `memreq_msg` out req width; `memreq_val` out 1; `memreq_rdy` in 1; `memreq_domain` out 1: shared memory request
- `memresp_msg` in resp width; `memresp_val` in 1; `memresp_rdy` out 1; `memresp_domain` in 1; `fail` in 1: shared memory response

## Operation
- **State register**: `IDLE`, `SEND`, `WAIT`. The block also holds a grant register `gnt` (1 bit), a priority register `prio` (1 bit, the preferred requester), and a latched request domain `dom_q`.
- **IDLE**
  - If exactly one `reqN_val` is high, set `gnt`=N.
  - If both are high, set `gnt`=`prio`.
  - Latch `dom_q`=`reqN_domain` of the winner, then go to `SEND`.
  - If neither is high, stay in `IDLE`.
  - All `reqN_rdy`=0 in this state.
- **SEND**
  - `memreq_msg`/`memreq_domain` = granted requester's `msg`/`domain`.
  - `memreq_val` = granted `val`.
  - Granted `rdy` = `memreq_rdy`; the other `rdy` = 0.
  - On the handshake (`val` & `rdy`): go to `WAIT` and set `prio`=~`gnt`.
  - If the granted `val` drops before the handshake (protocol violation), return to `IDLE` and leave `prio` unchanged.
- **WAIT**
  - Granted `respN_val` = `memresp_val` and `memresp_rdy` = granted `respN_rdy`.
  - Granted `respN_domain` = `memresp_domain`.
  - Granted `failN` = `fail & memresp_val`.
  - The non-granted `resp_val` and `fail` are 0.
  - On the response handshake, go to `IDLE`.
  - Every request, write included, waits for exactly one response.
- **Domain guard**: if `memresp_val` & `memresp_domain`=1 & `dom_q`=0:
  - Force the data field `resp_msg[clw-1:0]` to 0.
  - Force `failN`=1.
  - Pass the type, opaque and len fields through unchanged.
- Non-granted `resp_msg` outputs drive 0.
- `memresp_val` arriving in `IDLE` or `SEND` (spurious) is ignored; `memresp_rdy`=0 there.
- **Reset**, including mid-`SEND` or mid-`WAIT`:
  - State goes to `IDLE`; `prio`=0, `gnt`=0, `dom_q`=0.
  - Any in-flight transaction is abandoned.

## Timing
- Reset value of every output is 0: all `val`, `rdy`, `fail`, `domain` and `msg` outputs. Outputs are combinational from state and are 0 in `IDLE`.
- Arbitration costs one bubble cycle. With `reqN_val` in cycle 0, `memreq_val` rises in cycle 1.
- Minimum round trip, requester view: request accepted in cycle 1, response visible from cycle 2 (in `WAIT`, same cycle `memresp_val` rises). The next arbitration is in cycle 3.
- The arbiter adds no combinational path from `memreq_rdy` to `memreq_val`. There are combinational paths `memreq_rdy`→`reqN_rdy` and `respN_rdy`→`memresp_rdy`.
- Requesters must hold `msg`/`domain` stable while `val` is high (val/rdy protocol).

## Test plan
- **Single request**: `req0`, addr 0x100, domain 0; `memreq_rdy`=1; response data 0x1234 one cycle later.
  - Required: `memreq_val` in cycle 1, `resp0_val` with 0x1234 and `fail0`=0.
  - `resp1_val` stays 0 throughout.
- **Simultaneous requests**: both `val` high after reset.
  - Required grant order: 0 then 1.
  - Both reasserted together again: 0 is granted next (alternation), with a one-cycle `IDLE` gap each time.
- **Request backpressure**: `memreq_rdy`=0 for 3 cycles.
  - Required: state stays in `SEND` and `req0_rdy`=0 for those 3 cycles.
  - Handshake completes on cycle 4; `prio` flips only then.
- **Response backpressure**: `resp1_rdy`=0 for 2 cycles while `memresp_val`=1.
  - Required: `memresp_rdy`=0 for those cycles and the response is held.
  - Completes when `resp1_rdy`=1.
- **Domain guard**: `req0_domain`=0; response has `memresp_domain`=1 and data 0xDEADBEEF_...
  - Required: `resp0_msg` data field = 0, `fail0`=1, opaque field preserved.
  - Same case with `req0_domain`=1: data passes unchanged, `fail0`=`fail`.
- **Mid-transaction reset**: assert `reset`=0 in `WAIT`.
  - Required: next cycle all outputs are 0 and state is `IDLE`.
  - A later `memresp_val` is ignored and a new `req1` is granted normally.
